// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Steps the frequency tuning word (FTW) of the CORDIC NCO linearly from a
// start FTW to a stop FTW. Each FTW is held for the NCO pipeline latency
// plus a programmed number of settled samples. A settle tracker reports when
// the NCO outputs reflect the FTW currently being driven.
//
// Ports:
//   clk           master clock
//   rst           synchronous active-high reset
//   cfg_start_frq first FTW of the sweep
//   cfg_stop_frq  last FTW of the sweep
//   cfg_step      unsigned FTW increment magnitude
//   cfg_dwell     settled cycles held per step (0 behaves as 1)
//   cfg_repeat    1 = restart at the start FTW after the stop FTW
//   start         one-cycle pulse, begins a sweep when idle
//   abort         terminates a sweep in progress
//   frq           FTW driven to the NCO
//   busy          sweep in progress
//   settled       NCO output reflects the current frq
//   step_idx      index of the current step within this pass
//   done          one-cycle pulse at sweep completion
// ---------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int NCO_LAT = 20,  // must be >= 1
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cfg_start_frq,
  input  logic [31:0]        cfg_stop_frq,
  input  logic [31:0]        cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        frq,
  output logic               busy,
  output logic               settled,
  output logic [15:0]        step_idx,
  output logic               done
);

  localparam int                 LAT_W     = $clog2(NCO_LAT + 1);
  localparam logic [LAT_W-1:0]   LAT_MAX   = LAT_W'(NCO_LAT);
  localparam logic [LAT_W-1:0]   LAT_ONE   = 1;
  localparam logic [DWELL_W-1:0] DWELL_ONE = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Sweep configuration captured when a start is accepted.
  logic [31:0]        start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               repeat_q;
  logic               up_q;

  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;

  logic [31:0]        frq_nxt, step_frq;
  logic [15:0]        step_idx_nxt;
  logic               busy_nxt, done_nxt, cap_en;
  logic               settle_edge, dwell_exp, at_end;
  logic [32:0]        sum_up, diff_dn;

  assign settled = (lat_cnt == LAT_MAX);

  // SETTLE is left on the edge where settled rises, so every DWELL cycle is
  // a settled cycle and a step lasts exactly NCO_LAT + dwell cycles.
  assign settle_edge = (lat_cnt >= LAT_MAX - LAT_ONE);
  assign dwell_exp   = (dwell_cnt == DWELL_ONE);
  assign at_end      = (frq == stop_q) || (step_q == '0);

  // Next FTW, computed one bit wider so a carry or borrow out of 32 bits is
  // seen as overshooting the stop FTW and clamps instead of wrapping.
  always_comb begin
    sum_up  = {1'b0, frq} + {1'b0, step_q};
    diff_dn = {1'b0, frq} - {1'b0, step_q};
    if (up_q) begin
      step_frq = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[31:0];
    end else begin
      step_frq = (diff_dn[32] || (diff_dn[31:0] < stop_q)) ? stop_q : diff_dn[31:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (abort)            state_nxt = IDLE;
        else if (settle_edge) state_nxt = DWELL;
      end
      DWELL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (dwell_exp) begin
          if (at_end && !repeat_q) state_nxt = DONE;
          else                     state_nxt = SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values.
  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    frq_nxt       = frq;
    step_idx_nxt  = step_idx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    dwell_cnt_nxt = dwell_cnt;
    cap_en        = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start && !abort) begin
          frq_nxt      = cfg_start_frq;
          step_idx_nxt = '0;
          busy_nxt     = 1'b1;
          cap_en       = 1'b1;
        end
      end
      SETTLE: begin
        if (abort)            busy_nxt      = 1'b0;
        else if (settle_edge) dwell_cnt_nxt = dwell_q;
      end
      DWELL: begin
        if (abort) begin
          busy_nxt = 1'b0;
        end else begin
          dwell_cnt_nxt = dwell_cnt - DWELL_ONE;
          if (dwell_exp) begin
            if (at_end) begin
              if (repeat_q) begin
                frq_nxt      = start_q;
                step_idx_nxt = '0;
              end
            end else begin
              frq_nxt      = step_frq;
              step_idx_nxt = (step_idx == 16'hFFFF) ? step_idx : step_idx + 16'd1;
            end
          end
        end
      end
      DONE: begin
        busy_nxt = 1'b0;
        done_nxt = !abort;
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  // Settle tracker: restarts whenever frq takes a different value and
  // saturates at NCO_LAT. Reloading the same FTW does not restart it.
  always_comb begin
    if (frq_nxt != frq)         lat_nxt = '0;
    else if (lat_cnt != LAT_MAX) lat_nxt = lat_cnt + LAT_ONE;
    else                         lat_nxt = lat_cnt;
  end

  // State and data registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the captured configuration is reset too so the step logic never
      // operates on X after reset, even though it is reloaded on every start.
      state     <= IDLE;
      frq       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      lat_cnt   <= '0;
      dwell_cnt <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frq       <= frq_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      step_idx  <= step_idx_nxt;
      lat_cnt   <= lat_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      if (cap_en) begin
        start_q  <= cfg_start_frq;
        stop_q   <= cfg_stop_frq;
        step_q   <= cfg_step;
        dwell_q  <= (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
        repeat_q <= cfg_repeat;
        up_q     <= (cfg_stop_frq >= cfg_start_frq);
      end
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequences the frequency tuning word (FTW) of the CORDIC NCO through a linear stepped sweep from a start FTW to a stop FTW. Holds each step for a programmed number of samples. Tracks the NCO pipeline latency so downstream capture logic knows when sin/cos reflect the current FTW. Sits between the register/config block and the NCO `frq` input.

Parameters:
NCO_LAT, 20, cycles from an FTW change to the first NCO output sample at the new frequency.
DWELL_W, 16, width of the dwell counter.

Ports:
clk  in  1  master clock
rst  in  1  synchronous active-high reset
cfg_start_frq  in  32  first FTW of sweep
cfg_stop_frq  in  32  last FTW of sweep
cfg_step  in  32  unsigned FTW increment magnitude
cfg_dwell  in  DWELL_W  settled cycles held per step (0 treated as 1)
cfg_repeat  in  1  1 = restart at start FTW after stop FTW
start  in  1  one-cycle pulse, begins sweep
abort  in  1  level/pulse, terminates sweep
frq  out  32  FTW to NCO
busy  out  1  sweep in progress
settled  out  1  NCO output reflects current frq
step_idx  out  16  index of current step in this pass
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset values: frq=0, busy=0, done=0, step_idx=0, settled=0; all counters 0; state IDLE.
- Settle tracker, independent of state:
  - A latency counter is cleared on the cycle frq changes and increments, saturating at NCO_LAT.
  - settled = (counter == NCO_LAT).
  - After reset, settled rises on the NCO_LAT-th cycle after rst deasserts.
  - Loading a frq equal to the current value counts as no change.
- Config capture: cfg_* are registered on the cycle start is accepted. Later cfg changes have no effect until the next start.
- Direction: up if cfg_stop_frq >= cfg_start_frq, else down.
- State IDLE:
  - busy=0.
  - If start=1 and abort=0: frq<=cfg_start_frq, step_idx<=0, busy<=1, go to SETTLE.
  - start together with abort is ignored.
- State SETTLE: wait until settled=1, then load the dwell counter with max(cfg_dwell,1) and go to DWELL.
- State DWELL:
  - Decrement the dwell counter each cycle.
  - When it expires, on the same cycle compute the next step:
    - If frq == stop FTW (or cfg_step == 0):
      - cfg_repeat=1: frq<=start FTW, step_idx<=0, go to SETTLE.
      - Otherwise go to DONE.
    - Otherwise:
      - next = frq ± cfg_step, computed in 33 bits.
      - If next passes stop (overshoot, including 32-bit overflow/underflow), next=stop. There is no modular wrap.
      - frq<=next, step_idx<=step_idx+1, go to SETTLE.
- State DONE: done=1 for exactly one cycle, busy<=0, frq holds stop FTW, return to IDLE.
- start while busy=1 is ignored.
- abort (any non-IDLE state): next cycle state=IDLE, busy=0, frq holds its last value, no done pulse, step_idx holds.
- step_idx saturates at 16'hFFFF; it does not wrap within a pass.
- Total cycles from start accepted to done = N_steps × (NCO_LAT + max(cfg_dwell,1)) + 1, where N_steps = number of distinct FTWs.

Test Plan:
1. Reset, then idle 25 cycles -> frq=0, busy=0, done=0, step_idx=0; settled=0 through cycle 19, =1 from cycle 20 after rst release.
2. Up sweep: start=1000, stop=1300, step=100, dwell=4, repeat=0 -> frq 1000,1100,1200,1300, each held 24 cycles with settled high for the last 4. step_idx 0..3. done pulses once at cycle 97 after start. busy drops with done. frq stays 1300.
3. Clamp and down sweep:
   - start=0, stop=250, step=100 -> 0,100,200,250 then done.
   - start=32'h8000_0000, stop=32'h7FFF_FF00, step=32'h80 -> 8000_0000, 7FFF_FF80, 7FFF_FF00 then done.
4. Overflow guard: start=32'hFFFF_FF00, stop=32'hFFFF_FFFF, step=32'h100 -> FFFF_FF00, FFFF_FFFF, done. frq is never 0000_0000.
5. Repeat and abort: start=10, stop=30, step=10, dwell=1, repeat=1 -> 10,20,30,10,20..., step_idx returns to 0 at each restart, done never asserted. Assert abort during the DWELL of 20 -> busy=0 next cycle, frq stays 20, no done, settled stays 1.
6. Degenerate inputs:
   - step=0, dwell=0, start=stop=500 -> frq=500 for 21 cycles, then done.
   - A start pulse while busy has no effect.
   - start and abort in the same cycle from IDLE -> stays IDLE, frq unchanged.
   - rst asserted mid-sweep -> all outputs return to reset values next cycle.
